// File: rtl/led_pkg.sv
// Shared LED sequencing types: colour word, sequencer state encoding and
// the fixed eight-entry colour palette.
package led_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FADING = 2'd1,
        DWELL  = 2'd2
    } seq_state_t;

    localparam int MAX_COLORS = 8;

    // {R,G,B}: red, orange, yellow, green, cyan, blue, violet, white
    localparam rgb_t PALETTE [MAX_COLORS] = '{
        24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00,
        24'h00FFFF, 24'h0000FF, 24'h8000FF, 24'hFFFFFF
    };

    function automatic logic [2:0] next_index(input logic [2:0] idx, input int num_colors);
        return (idx == 3'(num_colors - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Two-flop synchroniser for a raw push-button followed by a rising-edge
// detector; a held button yields a single one-cycle pulse.
module button_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic pulse_out
);

    // [0] metastability catcher, [1] synchronised level, [2] previous level
    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], btn_in};
        end
    end

    // High in the cycle before the 3rd edge after the press, so the
    // consumer acts on that 3rd edge.
    assign pulse_out = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/color_sequencer.sv
// Steps a fading controller through the palette: fade to each colour, dwell,
// advance; a synchronised skip button forces an immediate advance.
module color_sequencer
    import led_pkg::*;
#(
    parameter int NUM_COLORS   = 8,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int DONE_BLANK   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        skip_btn,
    input  logic        transition_done,
    output logic [23:0] target_color,
    output logic [2:0]  color_index,
    output logic [1:0]  seq_state,
    output logic        color_advanced
);

    localparam int CNT_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int BLANK_W = (DONE_BLANK > 0) ? $clog2(DONE_BLANK + 1) : 1;
    localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(DONE_BLANK);

    seq_state_t         state_q, state_d;
    logic [2:0]         index_q, index_d;
    rgb_t               target_q, target_d;
    logic               advanced_q, advanced_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic               skip_pulse;
    logic               adv_req;
    logic [2:0]         index_next;

    button_edge_detect u_skip (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_in   (skip_btn),
        .pulse_out(skip_pulse)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            target_q   <= '0;
            advanced_q <= 1'b0;
            dwell_q    <= '0;
            blank_q    <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            target_q   <= target_d;
            advanced_q <= advanced_d;
            dwell_q    <= dwell_d;
            blank_q    <= blank_d;
        end
    end

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        target_d   = target_q;
        advanced_d = 1'b0;
        dwell_d    = dwell_q;
        blank_d    = blank_q;
        adv_req    = 1'b0;
        index_next = next_index(index_q, NUM_COLORS);

        // Dropping enable outranks skip and done; the index is kept for resume.
        if (!enable) begin
            state_d  = IDLE;
            target_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = FADING;
                    target_d = PALETTE[index_q];
                    blank_d  = BLANK_LOAD;
                end
                FADING: begin
                    if (skip_pulse) begin
                        adv_req = 1'b1;
                    end else if (blank_q != '0) begin
                        blank_d = blank_q - BLANK_W'(1);
                    end else if (transition_done) begin
                        state_d = DWELL;
                        dwell_d = '0;
                    end
                end
                DWELL: begin
                    if (skip_pulse || dwell_q == DWELL_LAST) begin
                        adv_req = 1'b1;
                    end else begin
                        dwell_d = dwell_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (adv_req) begin
            state_d    = FADING;
            index_d    = index_next;
            target_d   = PALETTE[index_next];
            advanced_d = 1'b1;
            blank_d    = BLANK_LOAD;
        end
    end

    assign target_color   = target_q;
    assign color_index    = index_q;
    assign seq_state      = state_q;
    assign color_advanced = advanced_q;

endmodule

// File: tb/tb_color_sequencer.sv
// Self-checking bench for color_sequencer: directed scenarios against fixed
// expectations, then randomised traffic against a cycle-level reference model.
module tb_color_sequencer;

    localparam int N  = 3;
    localparam int DW = 10;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        skip_btn = 1'b0;
    logic        transition_done = 1'b0;
    logic [23:0] target_color;
    logic [2:0]  color_index;
    logic [1:0]  seq_state;
    logic        color_advanced;

    int total = 0;
    int bad   = 0;

    logic [23:0] pal [8] = '{24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00,
                             24'h00FFFF, 24'h0000FF, 24'h8000FF, 24'hFFFFFF};

    // Reference model: mode 0 idle / 1 fading / 2 dwelling, with ages counted
    // upward since the last fade start and since dwell start.
    int          m_mode, m_idx, m_fade_age, m_dwell_age;
    logic [23:0] m_tgt;
    bit          m_adv;
    bit          h1, h2, h3;

    always #10 clk = ~clk;

    color_sequencer #(.NUM_COLORS(N), .DWELL_CYCLES(DW), .DONE_BLANK(DB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .skip_btn       (skip_btn),
        .transition_done(transition_done),
        .target_color   (target_color),
        .color_index    (color_index),
        .seq_state      (seq_state),
        .color_advanced (color_advanced)
    );

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_fade_age = 0; m_dwell_age = 0;
        m_tgt = '0; m_adv = 1'b0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    task automatic model_step();
        bit skip;
        skip  = h2 && !h3;   // button seen high two edges ago, low three edges ago
        m_adv = 1'b0;
        if (!enable) begin
            m_mode = 0;
            m_tgt  = '0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_fade_age = 0; m_tgt = pal[m_idx];
        end else if (skip || (m_mode == 2 && m_dwell_age == DW - 1)) begin
            m_idx = (m_idx + 1) % N;
            m_tgt = pal[m_idx]; m_adv = 1'b1; m_mode = 1; m_fade_age = 0;
        end else if (m_mode == 1) begin
            if (transition_done && m_fade_age >= DB) begin
                m_mode = 2; m_dwell_age = 0;
            end else begin
                m_fade_age++;
            end
        end else begin
            m_dwell_age++;
        end
        h3 = h2; h2 = h1; h1 = skip_btn;
    endtask

    // Inputs change on the falling edge; outputs are observed on the next one.
    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step(); else model_reset();
        @(negedge clk);
    endtask

    task automatic reach_dwell();
        repeat (DB + 1) cycle();
        transition_done = 1'b1;
        cycle();
        transition_done = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        total++; if (seq_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", seq_state); end
        total++; if (color_index !== 3'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", color_index); end
        total++; if (target_color !== 24'h0) begin bad++; $display("FAIL reset_target got=%h want=000000", target_color); end
        total++; if (color_advanced !== 1'b0) begin bad++; $display("FAIL reset_adv got=%b want=0", color_advanced); end
        reset_n = 1'b1;
        cycle();
        total++; if (seq_state !== 2'd0) begin bad++; $display("FAIL idle_hold got=%0d want=0", seq_state); end
    endtask

    task automatic test_start();
        enable = 1'b1;
        cycle();
        total++; if (target_color !== 24'hFF0000) begin bad++; $display("FAIL start_target got=%h want=ff0000", target_color); end
        total++; if (seq_state !== 2'd1) begin bad++; $display("FAIL start_state got=%0d want=1", seq_state); end
    endtask

    task automatic test_done_accept();
        repeat (4) cycle();
        transition_done = 1'b1;
        cycle();
        transition_done = 1'b0;
        total++; if (seq_state !== 2'd2) begin bad++; $display("FAIL done_to_dwell got=%0d want=2", seq_state); end
        repeat (9) cycle();
        total++; if (seq_state !== 2'd2 || color_advanced !== 1'b0) begin
            bad++; $display("FAIL dwell_early got state=%0d adv=%b want state=2 adv=0", seq_state, color_advanced);
        end
        cycle();
        total++; if (color_index !== 3'd1) begin bad++; $display("FAIL dwell_adv_index got=%0d want=1", color_index); end
        total++; if (color_advanced !== 1'b1) begin bad++; $display("FAIL dwell_adv_pulse got=%b want=1", color_advanced); end
        total++; if (seq_state !== 2'd1) begin bad++; $display("FAIL dwell_adv_state got=%0d want=1", seq_state); end
        total++; if (target_color !== 24'hFF8000) begin bad++; $display("FAIL dwell_adv_target got=%h want=ff8000", target_color); end
    endtask

    task automatic test_done_blank();
        transition_done = 1'b1;
        cycle();
        transition_done = 1'b0;
        total++; if (color_advanced !== 1'b0) begin bad++; $display("FAIL adv_one_cycle got=%b want=0", color_advanced); end
        total++; if (seq_state !== 2'd1) begin bad++; $display("FAIL blank_ignore got=%0d want=1", seq_state); end
        repeat (3) cycle();
        total++; if (seq_state !== 2'd1) begin bad++; $display("FAIL blank_stay got=%0d want=1", seq_state); end
    endtask

    task automatic test_wrap();
        int exp_idx [2] = '{2, 0};
        for (int k = 0; k < 2; k++) begin
            reach_dwell();
            repeat (DW) cycle();
            total++; if (color_index !== 3'(exp_idx[k]) || color_advanced !== 1'b1) begin
                bad++; $display("FAIL wrap_%0d got idx=%0d adv=%b want idx=%0d adv=1", k, color_index, color_advanced, exp_idx[k]);
            end
        end
        total++; if (target_color !== 24'hFF0000) begin bad++; $display("FAIL wrap_target got=%h want=ff0000", target_color); end
    endtask

    task automatic test_skip_hold();
        int advances = 0;
        reach_dwell();
        repeat (2) cycle();
        skip_btn = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            cycle();
            total++; if (color_advanced !== 1'b0 || color_index !== 3'd0) begin
                bad++; $display("FAIL skip_early_edge%0d got adv=%b idx=%0d want adv=0 idx=0", e, color_advanced, color_index);
            end
        end
        cycle();
        total++; if (color_advanced !== 1'b1 || color_index !== 3'd1 || seq_state !== 2'd1) begin
            bad++; $display("FAIL skip_edge3 got adv=%b idx=%0d st=%0d want adv=1 idx=1 st=1", color_advanced, color_index, seq_state);
        end
        repeat (17) begin
            cycle();
            if (color_advanced) advances++;
        end
        total++; if (advances != 0) begin bad++; $display("FAIL skip_held_extra got=%0d want=0", advances); end
        skip_btn = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic test_disable();
        reach_dwell();
        repeat (DW) cycle();
        reach_dwell();
        repeat (4) cycle();
        enable = 1'b0;
        cycle();
        total++; if (seq_state !== 2'd0 || target_color !== 24'h0 || color_index !== 3'd2) begin
            bad++; $display("FAIL disable got st=%0d tgt=%h idx=%0d want st=0 tgt=000000 idx=2", seq_state, target_color, color_index);
        end
        cycle();
        enable = 1'b1;
        cycle();
        total++; if (seq_state !== 2'd1 || target_color !== 24'hFFFF00 || color_index !== 3'd2 || color_advanced !== 1'b0) begin
            bad++; $display("FAIL reenable got st=%0d tgt=%h idx=%0d adv=%b want st=1 tgt=ffff00 idx=2 adv=0",
                            seq_state, target_color, color_index, color_advanced);
        end
    endtask

    task automatic test_reset_mid_fade();
        cycle();
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        total++; if (seq_state !== 2'd0 || color_index !== 3'd0 || target_color !== 24'h0 || color_advanced !== 1'b0) begin
            bad++; $display("FAIL async_reset got st=%0d idx=%0d tgt=%h adv=%b want all zero",
                            seq_state, color_index, target_color, color_advanced);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 1500; c++) begin
            enable          = ($urandom_range(0, 99) < 96);
            transition_done = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 8) skip_btn = ~skip_btn;
            cycle();
            total++;
            if (seq_state !== 2'(m_mode) || color_index !== 3'(m_idx) ||
                target_color !== m_tgt || color_advanced !== m_adv) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL random_c%0d got st=%0d idx=%0d tgt=%h adv=%b want st=%0d idx=%0d tgt=%h adv=%b",
                             c, seq_state, color_index, target_color, color_advanced, m_mode, m_idx, m_tgt, m_adv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_done_accept();
        test_done_blank();
        test_wrap();
        test_skip_hold();
        test_disable();
        test_reset_mid_fade();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
